// File: rtl/vram_slot_scheduler_pkg.sv
// vram_slot_scheduler_pkg: slot phase encodings, FIFO word layout and write counter limit.
package vram_slot_scheduler_pkg;
    typedef enum logic [1:0] {
        PH_POP  = 2'd0,
        PH_TILE = 2'd1,
        PH_ROW  = 2'd2,
        PH_PX   = 2'd3
    } phase_e;
    localparam int SEL_BIT  = 31;
    localparam int ADDR_MSB = 30;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == COUNT_MAX) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/vram_slot_scheduler_phase_gen.sv
// slot_phase_gen: free-running 4-phase slot counter, registered pixel/position clocks and slot mode latch.
module slot_phase_gen
    import vram_slot_scheduler_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   display_i,
    output phase_e phase_o,
    output logic   dotclk_o,
    output logic   posclk_o,
    output logic   mode_o
);
    phase_e phase_q, phase_d;
    logic   dot_q, pos_q, mode_q;
    assign phase_d = phase_e'(phase_q + 2'd1);
    // clocks are decoded from the next phase so they line up with phase without a combinational path
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q <= PH_POP;
            dot_q   <= 1'b0;
            pos_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            dot_q   <= (phase_d == PH_POP) || (phase_d == PH_TILE);
            pos_q   <= phase_d == PH_POP;
            if (phase_q == PH_PX) mode_q <= display_i;
        end
    end
    assign phase_o  = phase_q;
    assign dotclk_o = dot_q;
    assign posclk_o = pos_q;
    assign mode_o   = mode_q;
endmodule

// File: rtl/vram_slot_scheduler.sv
// vram_slot_scheduler: time-slices video memory into 4-cycle slots, either display reads
// or one FIFO pop plus its memory write, never mixed within a slot.
module vram_slot_scheduler
    import vram_slot_scheduler_pkg::*;
#(
    parameter int ADDR_BITS = 15,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_display_region,
    input  logic                 fifo_empty,
    input  logic [31:0]          fifo_data,
    output logic                 fifo_read,
    output logic [1:0]           phase,
    output logic                 dotclk,
    output logic                 posclk,
    output logic                 rd_tile,
    output logic                 rd_row,
    output logic                 rd_px,
    output logic                 mem_wr_en,
    output logic                 mem_sel,
    output logic [ADDR_BITS-1:0] mem_waddr,
    output logic [DATA_BITS-1:0] mem_wdata,
    output logic [15:0]          write_count,
    output logic                 mode_display
);
    phase_e               phase_q;
    logic                 mode_q, fifo_read_q, popped_q, commit;
    logic                 rd_tile_q, rd_row_q, rd_px_q, wr_en_q, sel_q;
    logic [ADDR_BITS-1:0] waddr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [15:0]          write_count_q, write_count_d;

    slot_phase_gen u_phase (
        .clk       (clk),
        .reset     (reset),
        .display_i (in_display_region),
        .phase_o   (phase_q),
        .dotclk_o  (dotclk),
        .posclk_o  (posclk),
        .mode_o    (mode_q)
    );

    assign commit        = popped_q && (phase_q == PH_TILE);
    assign write_count_d = commit ? sat_inc(write_count_q) : write_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_read_q   <= 1'b0;
            popped_q      <= 1'b0;
            rd_tile_q     <= 1'b0;
            rd_row_q      <= 1'b0;
            rd_px_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            sel_q         <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            write_count_q <= '0;
        end else begin
            // pop decision uses the same sample that latches the next slot's mode
            fifo_read_q   <= (phase_q == PH_PX) && !in_display_region && !fifo_empty;
            popped_q      <= fifo_read_q;
            rd_tile_q     <= mode_q && (phase_q == PH_POP);
            rd_row_q      <= mode_q && (phase_q == PH_TILE);
            rd_px_q       <= mode_q && (phase_q == PH_ROW);
            wr_en_q       <= commit;
            write_count_q <= write_count_d;
            if (commit) begin
                sel_q   <= fifo_data[SEL_BIT];
                waddr_q <= ADDR_BITS'(fifo_data[ADDR_MSB:ADDR_LSB]);
                wdata_q <= DATA_BITS'(fifo_data[DATA_MSB:DATA_LSB]);
            end
        end
    end

    assign phase        = phase_q;
    assign fifo_read    = fifo_read_q;
    assign rd_tile      = rd_tile_q;
    assign rd_row       = rd_row_q;
    assign rd_px        = rd_px_q;
    assign mem_wr_en    = wr_en_q;
    assign mem_sel      = sel_q;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = wdata_q;
    assign write_count  = write_count_q;
    assign mode_display = mode_q;
endmodule

// File: tb/tb_vram_slot_scheduler.sv
// tb_vram_slot_scheduler: directed scenario tasks with hand-computed expectations.
module tb_vram_slot_scheduler;
    logic        clk, reset, in_display_region, fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_read, dotclk, posclk, rd_tile, rd_row, rd_px, mem_wr_en, mem_sel, mode_display;
    logic [1:0]  phase;
    logic [14:0] mem_waddr;
    logic [15:0] mem_wdata, write_count;
    int          n_cmp = 0;
    int          n_bad = 0;

    vram_slot_scheduler dut (
        .clk               (clk),
        .reset             (reset),
        .in_display_region (in_display_region),
        .fifo_empty        (fifo_empty),
        .fifo_data         (fifo_data),
        .fifo_read         (fifo_read),
        .phase             (phase),
        .dotclk            (dotclk),
        .posclk            (posclk),
        .rd_tile           (rd_tile),
        .rd_row            (rd_row),
        .rd_px             (rd_px),
        .mem_wr_en         (mem_wr_en),
        .mem_sel           (mem_sel),
        .mem_waddr         (mem_waddr),
        .mem_wdata         (mem_wdata),
        .write_count       (write_count),
        .mode_display      (mode_display)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_phase(input logic [1:0] p);
        for (int i = 0; i < 8 && phase !== p; i++) step();
        n_cmp++;
        if (phase !== p) begin n_bad++; $display("FAIL align: phase=%0d want %0d", phase, p); end
    endtask

    task automatic do_reset;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; in_display_region = 1'b1; fifo_empty = 1'b0; fifo_data = 32'hFFFF_FFFF;
        step();
        step();
        n_cmp++;
        if ({phase, dotclk, posclk, fifo_read, mem_wr_en, rd_tile, rd_row, rd_px, mem_sel, mode_display} !== 11'd0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 0", {phase, dotclk, posclk, fifo_read, mem_wr_en, rd_tile, rd_row, rd_px, mem_sel, mode_display});
        end
        n_cmp++;
        if ({mem_waddr, mem_wdata, write_count} !== 47'd0) begin
            n_bad++; $display("FAIL reset_data: addr=%h data=%h cnt=%h want 0", mem_waddr, mem_wdata, write_count);
        end
        reset = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            step();
            n_cmp++;
            if ({phase, mode_display, fifo_read} !== {2'(p), 2'b00}) begin
                n_bad++; $display("FAIL release_p%0d: phase=%0d mode=%b rd=%b want mode 0", p, phase, mode_display, fifo_read);
            end
        end
        step();
        n_cmp++;
        if ({phase, posclk, mode_display, fifo_read} !== 5'b00110) begin
            n_bad++; $display("FAIL first_latch: phase=%0d pos=%b mode=%b rd=%b want 0 1 1 0", phase, posclk, mode_display, fifo_read);
        end
        in_display_region = 1'b0; fifo_empty = 1'b1;
    endtask

    task automatic test_idle;
        logic [3:0] dot_pat, pos_pat;
        logic [1:0] p;
        logic [8:0] exp;
        dot_pat = 4'b1100; pos_pat = 4'b1000;
        in_display_region = 1'b0; fifo_empty = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step();
            p = 2'((i + 1) % 4);
            exp = {p, dot_pat[3-p], pos_pat[3-p], 5'b0};
            n_cmp++;
            if ({phase, dotclk, posclk, fifo_read, mem_wr_en, rd_tile, rd_row, rd_px} !== exp) begin
                n_bad++; $display("FAIL idle_c%0d: got %b want %b", i, {phase, dotclk, posclk, fifo_read, mem_wr_en, rd_tile, rd_row, rd_px}, exp);
            end
        end
    endtask

    task automatic test_single_write;
        do_reset();
        fifo_data = 32'h8012_ABCD; fifo_empty = 1'b0;
        run_to_phase(2'd3);
        step();
        n_cmp++;
        if ({phase, fifo_read, mem_wr_en} !== 4'b0010) begin
            n_bad++; $display("FAIL sw_pop: phase=%0d rd=%b wr=%b want 0 1 0", phase, fifo_read, mem_wr_en);
        end
        step();
        fifo_empty = 1'b1;
        n_cmp++;
        if ({fifo_read, mem_wr_en} !== 2'b00) begin
            n_bad++; $display("FAIL sw_p1: rd=%b wr=%b want 0 0", fifo_read, mem_wr_en);
        end
        step();
        n_cmp++;
        if ({phase, mem_wr_en, mem_sel, mem_waddr, mem_wdata, write_count} !== {2'd2, 1'b1, 1'b1, 15'h0012, 16'hABCD, 16'd1}) begin
            n_bad++; $display("FAIL sw_write: ph=%0d wr=%b sel=%b addr=%h data=%h cnt=%0d want 2 1 1 0012 abcd 1", phase, mem_wr_en, mem_sel, mem_waddr, mem_wdata, write_count);
        end
        step();
        n_cmp++;
        if ({mem_wr_en, mem_sel, mem_waddr, mem_wdata, write_count} !== {1'b0, 1'b1, 15'h0012, 16'hABCD, 16'd1}) begin
            n_bad++; $display("FAIL sw_hold: wr=%b sel=%b addr=%h data=%h cnt=%0d want 0 1 0012 abcd 1", mem_wr_en, mem_sel, mem_waddr, mem_wdata, write_count);
        end
        step();
        n_cmp++;
        if (fifo_read !== 1'b0) begin n_bad++; $display("FAIL sw_nopop: rd=%b want 0", fifo_read); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w [3];
        w = '{32'h0001_1111, 32'h8002_2222, 32'h7FFF_3333};
        do_reset();
        fifo_empty = 1'b0;
        run_to_phase(2'd3);
        for (int s = 0; s < 3; s++) begin
            step();
            fifo_data = w[s];
            n_cmp++;
            if ({fifo_read, mem_wr_en} !== 2'b10) begin
                n_bad++; $display("FAIL b2b_pop%0d: rd=%b wr=%b want 1 0", s, fifo_read, mem_wr_en);
            end
            step();
            if (s == 2) fifo_empty = 1'b1;
            n_cmp++;
            if ({fifo_read, mem_wr_en} !== 2'b00) begin
                n_bad++; $display("FAIL b2b_p1_%0d: rd=%b wr=%b want 0 0", s, fifo_read, mem_wr_en);
            end
            step();
            n_cmp++;
            if ({mem_wr_en, rd_tile, rd_row, rd_px, mem_sel, mem_waddr, mem_wdata, write_count} !== {4'b1000, w[s], 16'(s + 1)}) begin
                n_bad++; $display("FAIL b2b_wr%0d: wr=%b word=%h cnt=%0d want 1 %h %0d", s, mem_wr_en, {mem_sel, mem_waddr, mem_wdata}, write_count, w[s], s + 1);
            end
            step();
            n_cmp++;
            if (mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL b2b_p3_%0d: wr=%b want 0", s, mem_wr_en); end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({fifo_read, mem_wr_en, write_count} !== {2'b00, 16'd3}) begin
                n_bad++; $display("FAIL b2b_tail%0d: rd=%b wr=%b cnt=%0d want 0 0 3", i, fifo_read, mem_wr_en, write_count);
            end
        end
    endtask

    task automatic test_display_switch;
        logic [2:0] exp_rd [4];
        exp_rd = '{3'b000, 3'b100, 3'b010, 3'b001};
        do_reset();
        fifo_data = 32'h0005_BEEF; fifo_empty = 1'b0;
        run_to_phase(2'd3);
        step();
        n_cmp++;
        if (fifo_read !== 1'b1) begin n_bad++; $display("FAIL ds_pop: rd=%b want 1", fifo_read); end
        step();
        in_display_region = 1'b1;
        step();
        n_cmp++;
        if ({mem_wr_en, mode_display, mem_wdata, write_count} !== {2'b10, 16'hBEEF, 16'd1}) begin
            n_bad++; $display("FAIL ds_write: wr=%b mode=%b data=%h cnt=%0d want 1 0 beef 1", mem_wr_en, mode_display, mem_wdata, write_count);
        end
        step();
        step();
        n_cmp++;
        if ({phase, mode_display, fifo_read} !== 4'b0010) begin
            n_bad++; $display("FAIL ds_mode: ph=%0d mode=%b rd=%b want 0 1 0", phase, mode_display, fifo_read);
        end
        for (int p = 1; p <= 3; p++) begin
            step();
            n_cmp++;
            if ({rd_tile, rd_row, rd_px, fifo_read, mem_wr_en} !== {exp_rd[p], 2'b00}) begin
                n_bad++; $display("FAIL ds_rd_p%0d: rd=%b pop=%b wr=%b want %b 0 0", p, {rd_tile, rd_row, rd_px}, fifo_read, mem_wr_en, exp_rd[p]);
            end
        end
    endtask

    task automatic test_reset_abort;
        in_display_region = 1'b0; fifo_data = 32'h80FF_1234; fifo_empty = 1'b0;
        run_to_phase(2'd3);
        step();
        n_cmp++;
        if (fifo_read !== 1'b1) begin n_bad++; $display("FAIL ra_pop: rd=%b want 1", fifo_read); end
        step();
        reset = 1'b0;
        step();
        n_cmp++;
        if ({phase, dotclk, posclk, fifo_read, mem_wr_en, rd_tile, rd_row, rd_px, mem_sel, mode_display, mem_waddr, mem_wdata, write_count} !== 58'd0) begin
            n_bad++; $display("FAIL ra_state: wr=%b sel=%b addr=%h data=%h cnt=%0d ph=%0d want all 0", mem_wr_en, mem_sel, mem_waddr, mem_wdata, write_count, phase);
        end
        reset = 1'b1; fifo_empty = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if ({mem_wr_en, write_count} !== 17'd0) begin
                n_bad++; $display("FAIL ra_after%0d: wr=%b cnt=%0d want 0 0", i, mem_wr_en, write_count);
            end
        end
    endtask

    task automatic test_saturate;
        do_reset();
        force dut.write_count_q = 16'hFFFE;
        step();
        release dut.write_count_q;
        n_cmp++;
        if (write_count !== 16'hFFFE) begin n_bad++; $display("FAIL sat_preload: cnt=%h want fffe", write_count); end
        fifo_data = 32'h0003_0003; fifo_empty = 1'b0;
        run_to_phase(2'd3);
        for (int s = 0; s < 3; s++) begin
            step();
            step();
            if (s == 2) fifo_empty = 1'b1;
            step();
            n_cmp++;
            if ({mem_wr_en, write_count} !== {1'b1, 16'hFFFF}) begin
                n_bad++; $display("FAIL sat_w%0d: wr=%b cnt=%h want 1 ffff", s, mem_wr_en, write_count);
            end
            step();
        end
        step();
        n_cmp++;
        if (write_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_final: cnt=%h want ffff", write_count); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_write();
        test_back_to_back();
        test_display_switch();
        test_reset_abort();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
